// File: rtl/sprite_draw_arbiter_pkg.sv
// Shared definitions for the sprite draw arbiter: FSM encoding, color width
// and default screen geometry.
package sprite_draw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } draw_state_t;

    localparam int COLOR_W      = 3;
    localparam int SCREEN_X_DEF = 160;
    localparam int SCREEN_Y_DEF = 120;
    localparam int WIDTH_X_DEF  = 8;
    localparam int WIDTH_Y_DEF  = 7;

endpackage

// File: rtl/sprite_draw_arbiter_if.sv
// Bundle of request, sprite-RAM and VGA plot signals between the object logic
// (master) and the sprite draw arbiter (slave).
interface sprite_draw_arbiter_if
    import sprite_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH_SX = 4,
    parameter int WIDTH_SY = 3,
    parameter int WIDTH_X  = WIDTH_X_DEF,
    parameter int WIDTH_Y  = WIDTH_Y_DEF
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH_X-1:0] org_x;
    logic [NUM_REQ*WIDTH_Y-1:0] org_y;
    logic [NUM_REQ-1:0]         ack;
    logic [SEL_W-1:0]           sel;
    logic [WIDTH_SX-1:0]        sx;
    logic [WIDTH_SY-1:0]        sy;
    logic [COLOR_W-1:0]         color_in;
    logic [WIDTH_X-1:0]         vga_x;
    logic [WIDTH_Y-1:0]         vga_y;
    logic [COLOR_W-1:0]         vga_color;
    logic                       vga_plot;
    logic                       busy;

    modport master (
        output req, org_x, org_y, color_in,
        input  ack, sel, sx, sy, vga_x, vga_y, vga_color, vga_plot, busy
    );

    modport slave (
        input  req, org_x, org_y, color_in,
        output ack, sel, sx, sy, vga_x, vga_y, vga_color, vga_plot, busy
    );

endinterface

// File: rtl/sprite_draw_arbiter_rr_arbiter.sv
// Round-robin requester select; the pointer holds the last granted index and
// advances only when grant_en is asserted.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic               any_req,
    output logic [SEL_W-1:0]   winner
);
    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] cand;

    // Walk from lowest to highest priority so the nearest requester after
    // last_q is the final one written.
    always_comb begin
        winner  = last_q;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            cand = SEL_W'((32'(last_q) + i) % NUM_REQ);
            if (req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= SEL_W'(NUM_REQ - 1);
        end else if (grant_en) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Time-shares one sprite scan/plot datapath among NUM_REQ objects: grants in
// round-robin order, sweeps the sprite RAM and emits clipped plot writes.
module sprite_draw_arbiter
    import sprite_draw_arbiter_pkg::*;
#(
    parameter int                 NUM_REQ           = 4,
    parameter int                 SPRITE_W          = 10,
    parameter int                 SPRITE_H          = 6,
    parameter int                 WIDTH_SX          = 4,
    parameter int                 WIDTH_SY          = 3,
    parameter int                 WIDTH_X           = WIDTH_X_DEF,
    parameter int                 WIDTH_Y           = WIDTH_Y_DEF,
    parameter int                 SCREEN_X          = SCREEN_X_DEF,
    parameter int                 SCREEN_Y          = SCREEN_Y_DEF,
    parameter bit                 TRANSPARENT_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_draw_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH_SX-1:0] SX_LAST = WIDTH_SX'(SPRITE_W - 1);
    localparam logic [WIDTH_SY-1:0] SY_LAST = WIDTH_SY'(SPRITE_H - 1);

    draw_state_t state_q, state_d;
    logic               grant_en, any_req, last_pix;
    logic [SEL_W-1:0]   winner, sel_q;
    logic [WIDTH_X-1:0] org_x_q;
    logic [WIDTH_Y-1:0] org_y_q;
    logic [WIDTH_SX-1:0] sx_q, sx_d;
    logic [WIDTH_SY-1:0] sy_q, sy_d;
    logic               valid_d;
    logic [WIDTH_X:0]   px;
    logic [WIDTH_Y:0]   py;
    logic               transparent;
    logic               plot_q;
    logic [WIDTH_X-1:0] vga_x_q;
    logic [WIDTH_Y-1:0] vga_y_q;
    logic [COLOR_W-1:0] vga_color_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req),
        .grant_en (grant_en),
        .any_req  (any_req),
        .winner   (winner)
    );

    assign last_pix = (sx_q == SX_LAST) && (sy_q == SY_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_en = 1'b1;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN:  if (last_pix) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant latches the owner and origin; SCAN walks the sprite row-major.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else if (grant_en) begin
            sel_q   <= winner;
            org_x_q <= bus.org_x[winner*WIDTH_X +: WIDTH_X];
            org_y_q <= bus.org_y[winner*WIDTH_Y +: WIDTH_Y];
            sx_q    <= '0;
            sy_q    <= '0;
        end else if (state_q == ST_SCAN) begin
            if (sx_q == SX_LAST) begin
                sx_q <= '0;
                sy_q <= (sy_q == SY_LAST) ? '0 : sy_q + WIDTH_SY'(1);
            end else begin
                sx_q <= sx_q + WIDTH_SX'(1);
            end
        end
    end

    assign px          = {1'b0, org_x_q} + (WIDTH_X+1)'(sx_d);
    assign py          = {1'b0, org_y_q} + (WIDTH_Y+1)'(sy_d);
    assign transparent = TRANSPARENT_EN && (bus.color_in == TRANSPARENT_COLOR);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d     <= 1'b0;
            sx_d        <= '0;
            sy_d        <= '0;
            plot_q      <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
        end else begin
            valid_d     <= (state_q == ST_SCAN);
            sx_d        <= sx_q;
            sy_d        <= sy_q;
            plot_q      <= valid_d && (px < (WIDTH_X+1)'(SCREEN_X))
                           && (py < (WIDTH_Y+1)'(SCREEN_Y)) && !transparent;
            vga_x_q     <= px[WIDTH_X-1:0];
            vga_y_q     <= py[WIDTH_Y-1:0];
            vga_color_q <= bus.color_in;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sx        = sx_q;
    assign bus.sy        = sy_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ack       = (state_q == ST_DONE) ? (NUM_REQ'(1) << sel_q) : '0;
    assign bus.vga_plot  = plot_q;
    assign bus.vga_x     = vga_x_q;
    assign bus.vga_y     = vga_y_q;
    assign bus.vga_color = vga_color_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Randomized scoreboard bench for sprite_draw_arbiter with a pixel-list
// reference model and a per-cycle output monitor.
module tb_sprite_draw_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int SPRITE_W = 10;
    localparam int SPRITE_H = 6;
    localparam int WIDTH_SX = 4;
    localparam int WIDTH_SY = 3;
    localparam int WIDTH_X  = 8;
    localparam int WIDTH_Y  = 7;
    localparam int SCREEN_X = 160;
    localparam int SCREEN_Y = 120;
    localparam int P        = SPRITE_W * SPRITE_H;

    typedef struct { int cyc; int x; int y; int color; } plot_t;
    typedef struct { int id; int grant; int cyc; } draw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sprite_draw_arbiter_if #(
        .NUM_REQ(NUM_REQ), .WIDTH_SX(WIDTH_SX), .WIDTH_SY(WIDTH_SY),
        .WIDTH_X(WIDTH_X), .WIDTH_Y(WIDTH_Y)
    ) bus ();

    sprite_draw_arbiter #(
        .NUM_REQ(NUM_REQ), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
        .WIDTH_SX(WIDTH_SX), .WIDTH_SY(WIDTH_SY), .WIDTH_X(WIDTH_X),
        .WIDTH_Y(WIDTH_Y), .SCREEN_X(SCREEN_X), .SCREEN_Y(SCREEN_Y),
        .TRANSPARENT_EN(1'b1), .TRANSPARENT_COLOR(3'b000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    plot_t pq[$];
    draw_t aq[$];
    logic [2:0] ram [NUM_REQ][SPRITE_H][SPRITE_W];
    int org_xs[NUM_REQ];
    int org_ys[NUM_REQ];
    int rr_last = NUM_REQ - 1;
    int free_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sprite RAM: one cycle of read latency
    always @(posedge clk) begin
        if (int'(bus.sx) < SPRITE_W && int'(bus.sy) < SPRITE_H)
            bus.color_in <= ram[bus.sel][bus.sy][bus.sx];
        else
            bus.color_in <= 3'b000;
    end

    // ---------------- reference model ----------------
    function automatic int pick(input logic [NUM_REQ-1:0] mask);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (rr_last + k) % NUM_REQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic push_draw(input int id, input int g);
        for (int y = 0; y < SPRITE_H; y++) begin
            for (int x = 0; x < SPRITE_W; x++) begin
                int px, py, col;
                px  = org_xs[id] + x;
                py  = org_ys[id] + y;
                col = int'(ram[id][y][x]);
                if (px < SCREEN_X && py < SCREEN_Y && col != 0)
                    pq.push_back('{g + 3 + y*SPRITE_W + x, px, py, col});
            end
        end
        aq.push_back('{id, g, g + P + 2});
        rr_last  = id;
        free_cyc = g + P + 3;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive_orgs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.org_x[i*WIDTH_X +: WIDTH_X] = WIDTH_X'(org_xs[i]);
            bus.org_y[i*WIDTH_Y +: WIDTH_Y] = WIDTH_Y'(org_ys[i]);
        end
    endtask

    task automatic random_orgs();
        for (int i = 0; i < NUM_REQ; i++) begin
            org_xs[i] = $urandom_range(0, 255);
            org_ys[i] = $urandom_range(0, 127);
        end
        drive_orgs();
    endtask

    // mode 0: any color, 1: never transparent, 2: transparent on even sx
    task automatic fill_ram(input int mode);
        for (int r = 0; r < NUM_REQ; r++)
            for (int y = 0; y < SPRITE_H; y++)
                for (int x = 0; x < SPRITE_W; x++) begin
                    if (mode == 0)               ram[r][y][x] = 3'($urandom_range(0, 7));
                    else if (mode == 2 && x % 2 == 0) ram[r][y][x] = 3'b000;
                    else                         ram[r][y][x] = 3'($urandom_range(1, 7));
                end
    endtask

    task automatic draw(input logic [NUM_REQ-1:0] mask, input int drop_off, input bit chg_org);
        int g, id;
        goto(free_cyc);
        bus.req = mask;
        g  = cyc;
        id = pick(mask);
        push_draw(id, g);
        goto(g + drop_off);
        if (chg_org) begin
            org_xs[id] = (org_xs[id] + 37) % 256;
            drive_orgs();
        end
        bus.req = '0;
        if (chg_org) begin
            // later draws of this requester use the new origin
            goto(free_cyc);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.ack !== '0 || bus.vga_plot !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== '0 ||
            bus.sx !== '0 || bus.sy !== '0 || bus.vga_x !== '0 || bus.vga_y !== '0 ||
            bus.vga_color !== '0) begin
            errors++;
            $display("FAIL %s cyc=%0d got ack=%b plot=%b busy=%b sel=%0d sx=%0d sy=%0d x=%0d y=%0d c=%0d, want all 0",
                     name, cyc, bus.ack, bus.vga_plot, bus.busy, bus.sel, bus.sx, bus.sy,
                     bus.vga_x, bus.vga_y, bus.vga_color);
        end
    endtask

    // ---------------- monitor ----------------
    plot_t              e;
    bit                 exp_p, exp_busy;
    int                 exp_sel;
    logic [NUM_REQ-1:0] exp_ack;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_p = (pq.size() > 0) && (pq[0].cyc == cyc);
            if (exp_p || bus.vga_plot) begin
                checks++;
                if (!exp_p) begin
                    errors++;
                    $display("FAIL plot_unexpected cyc=%0d got (%0d,%0d,c%0d) want no plot",
                             cyc, bus.vga_x, bus.vga_y, bus.vga_color);
                end else begin
                    e = pq.pop_front();
                    if (bus.vga_plot !== 1'b1 || int'(bus.vga_x) != e.x ||
                        int'(bus.vga_y) != e.y || int'(bus.vga_color) != e.color) begin
                        errors++;
                        $display("FAIL plot cyc=%0d got plot=%b (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 cyc, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_color,
                                 e.x, e.y, e.color);
                    end
                end
            end

            exp_busy = 1'b0;
            exp_sel  = 0;
            exp_ack  = '0;
            foreach (aq[i]) begin
                if (cyc > aq[i].grant && cyc <= aq[i].cyc) begin
                    exp_busy = 1'b1;
                    exp_sel  = aq[i].id;
                    if (cyc == aq[i].cyc) exp_ack = NUM_REQ'(1) << aq[i].id;
                end
            end
            checks++;
            if (bus.busy !== exp_busy || bus.ack !== exp_ack ||
                (exp_busy && int'(bus.sel) != exp_sel)) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got busy=%b ack=%b sel=%0d want busy=%b ack=%b sel=%0d",
                         cyc, bus.busy, bus.ack, bus.sel, exp_busy, exp_ack, exp_sel);
            end
            if (aq.size() > 0 && aq[0].cyc == cyc) void'(aq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int g;
        bus.req   = '0;
        bus.org_x = '0;
        bus.org_y = '0;
        reset     = 1'b1;
        repeat (3) step();
        check_zero("reset_state");
        reset    = 1'b0;
        mon_en   = 1'b1;
        free_cyc = cyc;

        // all requesters held: five back-to-back grants in rotation
        fill_ram(1);
        random_orgs();
        bus.req = '1;
        g = cyc;
        for (int k = 0; k < 5; k++) push_draw(pick('1), g + k*(P+3));
        goto(g + 4*(P+3) + 1);
        bus.req = '0;

        // single request, known origin
        fill_ram(1);
        org_xs[0] = 20; org_ys[0] = 30; drive_orgs();
        draw(4'b0001, P+2, 1'b0);

        // clipping at the bottom-right corner
        fill_ram(1);
        org_xs[2] = 155; org_ys[2] = 117; drive_orgs();
        draw(4'b0100, P+2, 1'b0);

        // transparency on even columns
        fill_ram(2);
        org_xs[3] = 40; org_ys[3] = 50; drive_orgs();
        draw(4'b1000, P+2, 1'b0);

        // origin change and request drop mid-draw
        fill_ram(0);
        random_orgs();
        draw(4'b0010, 10, 1'b1);

        // random masks, origins and sprite contents
        repeat (8) begin
            fill_ram(0);
            random_orgs();
            draw(NUM_REQ'($urandom_range(1, 15)), P+2, 1'b0);
        end

        // reset in cycle 20 of a draw abandons it without ack
        fill_ram(1);
        random_orgs();
        goto(free_cyc);
        bus.req = 4'b0001;
        g = cyc;
        push_draw(pick(4'b0001), g);
        goto(g + 20);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 4'b0010;
        while (pq.size() > 0 && pq[$].cyc >= cyc) void'(pq.pop_back());
        while (aq.size() > 0 && aq[$].cyc >= cyc) void'(aq.pop_back());
        rr_last = NUM_REQ - 1;
        #2;
        check_zero("reset_mid_draw");
        g = cyc;
        push_draw(pick(4'b0010), g);
        goto(g + P + 2);
        bus.req = '0;

        goto(free_cyc + 3);
        checks++;
        if (pq.size() != 0 || aq.size() != 0) begin
            errors++;
            $display("FAIL drained got plots_left=%0d acks_left=%0d want 0 and 0", pq.size(), aq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_draw_arbiter.md
# sprite_draw_arbiter

Shares one sprite scan/plot datapath among `NUM_REQ` game objects (frog, cars, logs, …). The block sits between the object logic and the VGA adapter. It grants one requester at a time in round-robin order and sweeps that sprite's local (sx, sy) coordinates across the requester's sprite RAM. It then offsets each returned pixel by the requester's screen origin and emits clipped, transparency-filtered plot writes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; `SEL_W` = clog2(`NUM_REQ`).
- `SPRITE_W`, 10: sprite width in pixels.
- `SPRITE_H`, 6: sprite height in pixels.
- `WIDTH_SX`, 4 / `WIDTH_SY`, 3: local coordinate widths.
- `WIDTH_X`, 8 / `WIDTH_Y`, 7: screen coordinate widths.
- `SCREEN_X`, 160 / `SCREEN_Y`, 120: visible screen size, used for clipping.
- `TRANSPARENT_EN`, 1: enables the transparent-color skip.
- `TRANSPARENT_COLOR`, 3'b000: color that is never plotted when `TRANSPARENT_EN` is 1.

Ports (one clock, `clk`; reset is synchronous and active-high, `reset`):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `req`  in  NUM_REQ  draw request per requester; held high until `ack`.
- `org_x`  in  NUM_REQ*WIDTH_X  packed screen origin X; slot i = bits [i*WIDTH_X +: WIDTH_X].
- `org_y`  in  NUM_REQ*WIDTH_Y  packed screen origin Y, same packing.
- `ack`  out  NUM_REQ  one-cycle done pulse to the granted requester.
- `sel`  out  SEL_W  index of the granted requester; drives the external sprite-RAM color mux.
- `sx`  out  WIDTH_SX  sprite RAM local X address.
- `sy`  out  WIDTH_SY  sprite RAM local Y address.
- `color_in`  in  3  sprite RAM output; valid one cycle after `sx`/`sy`.
- `vga_x`  out  WIDTH_X  plot X coordinate.
- `vga_y`  out  WIDTH_Y  plot Y coordinate.
- `vga_color`  out  3  plot color.
- `vga_plot`  out  1  plot write enable.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - If any `req` is high, choose a winner by round robin. Search starts at (last granted + 1) mod `NUM_REQ`.
  - Register `sel`, latch the winner's origin, set sx = sy = 0, go to SCAN.
  - If no `req` is high, stay in IDLE.
- SCAN:
  - One (sx, sy) per cycle, row-major: sx increments, wraps at `SPRITE_W`-1 to 0, and sy then increments.
  - Issuing (`SPRITE_W`-1, `SPRITE_H`-1) is the last SCAN cycle; go to DRAIN.
- DRAIN: one cycle with no new address issued. Go to DONE.
- DONE: `ack[sel]` is high for this single cycle. Go to IDLE.
- Pipeline: a valid bit and the (sx, sy) pair are delayed one cycle to align with `color_in`. The plot outputs are registered from that stage.
- Plot arithmetic:
  - px = org_x + sx_d and py = org_y + sy_d, each computed at width+1 bits.
  - `vga_plot` = valid_d AND px < `SCREEN_X` AND py < `SCREEN_Y` AND NOT(`TRANSPARENT_EN` AND color_in == `TRANSPARENT_COLOR`).
  - `vga_x`/`vga_y` are the low bits of px/py; `vga_color` = color_in. All are registered.
  - Clipped or transparent pixels still consume their cycle; there is no compaction.
- Origin and `sel` are latched at grant. Changes to `org_x`/`org_y`/`req` mid-draw are ignored.
- If `req` drops mid-draw, the draw still completes and `ack` still pulses.
- The round-robin pointer updates only at grant.
- Reset state: pointer set so requester 0 has top priority after reset.
- Reset at any point:
  - Next cycle is IDLE; pipeline valid cleared.
  - `ack`, `vga_plot`, `busy`, `sel`, `sx`, `sy`, `vga_x`, `vga_y`, `vga_color` are all 0.
  - Any in-flight draw is abandoned with no `ack`.

## Timing
- Let P = `SPRITE_W`*`SPRITE_H`, and let cycle 0 be the IDLE cycle in which the grant is made.
- SCAN occupies cycles 1..P. Address (sx, sy) is issued at cycle k; `color_in` is valid at k+1; `vga_plot` for that pixel is at k+2.
- First possible `vga_plot` is cycle 3; last is cycle P+2.
- DRAIN is cycle P+1. DONE is cycle P+2, where `ack` coincides with the last pixel's plot.
- IDLE at P+3 can grant again; minimum request-to-request period is P+3 cycles.
- `busy` is high in cycles 1..P+2.
- A requester must deassert `req` by the cycle after `ack`, otherwise it is eligible again. Round robin still rotates past it.

## Structure
- Shared package/header holds: the FSM state encoding, the color width constant (3), and the screen defaults (160x120, 8/7 bits).
- Sub-module `rr_arbiter`: combinational round-robin winner select plus a registered pointer, parameterized by `NUM_REQ`, with `grant_en` and `winner` ports.
- Everything else (FSM, address counters, delay stage, plot registers) lives in `sprite_draw_arbiter`.

## Test plan
- Single request, defaults: `req`=0001, org (20,30), RAM returns non-transparent colors. Expect 60 `vga_plot` pulses in cycles 3..62, first at (20,30), last at (29,35); `ack[0]` in cycle 62; `busy` high in cycles 1..62.
- All four `req` held high: grant order 0,1,2,3,0. Each grant begins 63 cycles after the previous one.
- Clipping: org (155,117). Only pixels with x<160 and y<120 are plotted (5x3 = 15 plots); `ack` still arrives in cycle 62.
- Transparency: RAM returns 3'b000 on even sx. Expect 30 plots; `vga_color` is never 000 while `vga_plot` is high.
- Reset asserted in cycle 20 of a draw: next cycle state is IDLE, all outputs 0, no `ack`. With `req`=0010 held, the next grant goes to requester 1.
- Mid-draw change: `org_x` changes and `req` drops at cycle 10. All plots still use the latched origin, and `ack` still pulses in cycle 62.
